// File: rtl/agc_fetch_sequencer.sv
// agc_fetch_sequencer: PC holder and instruction fetcher feeding the decoder over valid/ready
module agc_fetch_sequencer #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'o4000,
    parameter logic [WORD_W-1:0] EXTEND_WORD = 15'o00006
) (
    input  logic              tp4,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              extend,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] pc
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, SQUASH = 2'd2, HOLD = 2'd3;
    logic [1:0] state;
    logic [ADDR_W-1:0] pc_inc, hold_next;
    always_comb begin
        pc_inc = pc + ADDR_W'(1);
        hold_next = branch_en ? branch_addr : pc_inc;
        mem_req = (state == REQ) || (state == SQUASH);
        instr_valid = state == HOLD;
    end
    always_ff @(posedge tp4 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            mem_addr <= RESET_PC;
            instr <= '0;
            extend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    mem_addr <= pc;
                end
                REQ: begin
                    if (branch_en) begin
                        pc <= branch_addr;
                        extend <= 1'b0;
                        if (mem_ack) mem_addr <= branch_addr;
                        else state <= SQUASH;
                    end else if (mem_ack && mem_data == EXTEND_WORD) begin
                        extend <= 1'b1;
                        pc <= pc_inc;
                        mem_addr <= pc_inc;
                    end else if (mem_ack) begin
                        instr <= mem_data;
                        state <= HOLD;
                    end
                end
                // the stale read must finish before the redirected one is issued
                SQUASH: begin
                    if (branch_en) begin
                        pc <= branch_addr;
                        extend <= 1'b0;
                    end
                    if (mem_ack) begin
                        mem_addr <= branch_en ? branch_addr : pc;
                        state <= REQ;
                    end
                end
                default: begin
                    if (branch_en || instr_ready) begin
                        pc <= hold_next;
                        mem_addr <= hold_next;
                        extend <= 1'b0;
                        state <= REQ;
                    end
                end
            endcase
        end
    end
endmodule
